// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the RV32 datapath: sized/sign-extended loads and byte-masked stores
// into an internal word array, with a wait-state stall handshake. Optional macro: DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, next_state;
  logic [3:0]    wait_cnt;
  logic          req, commit, access_ok;

  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_func3;
  logic          lat_rd, lat_wr;

  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_func3;
  logic          cur_rd, cur_wr;
  logic [AW-1:0] cur_idx;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word, load_val, st_data;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [3:0]    be;

  logic          unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign req     = Memread | Memwrite;
  assign cur_idx = cur_addr[AW+1:2];

  // Live inputs on the accepting cycle (needed when WAIT_CYCLES is 0), latched copy afterwards
  always_comb begin
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_func3 = lat_func3;
    cur_rd    = lat_rd;
    cur_wr    = lat_wr;
    if (state == S_IDLE) begin
      cur_addr  = addr[AW+1:0];
      cur_wdata = wdata;
      cur_func3 = func3;
      cur_rd    = Memread;
      cur_wr    = Memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    done       = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            commit     = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (wait_cnt <= 4'd1) begin
          next_state = S_RESP;
          commit     = 1'b1;
        end
      end
      S_RESP: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rd_word = mem[cur_idx];
    case (cur_addr[1:0])
      2'd0:    lane_byte = rd_word[7:0];
      2'd1:    lane_byte = rd_word[15:8];
      2'd2:    lane_byte = rd_word[23:16];
      default: lane_byte = rd_word[31:24];
    endcase
    lane_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_func3)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_val = {24'd0, lane_byte};
      3'b101:  load_val = {16'd0, lane_half};
      default: load_val = rd_word;
    endcase
  end

  // Store lanes: replicate the data and let the byte enables pick the target lanes
  always_comb begin
    case (cur_func3)
      3'b000: begin
        be      = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = cur_wdata;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic is_half, is_word, mis, mis_q;

  always_comb begin
    if (cur_wr) begin
      is_half = (cur_func3 == 3'b001);
      is_word = (cur_func3 != 3'b000) && (cur_func3 != 3'b001);
    end else begin
      is_half = (cur_func3[1:0] == 2'b01);
      is_word = cur_func3[1];
    end
    mis = (is_half & cur_addr[0]) | (is_word & (cur_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset)       mis_q <= 1'b0;
    else if (commit) mis_q <= mis;
  end

  assign access_ok = ~mis;
  assign misalign  = done & mis_q;
`else
  assign access_ok = 1'b1;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata     <= '0;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_func3 <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        lat_addr  <= addr[AW+1:0];
        lat_wdata <= wdata;
        lat_func3 <= func3;
        lat_rd    <= Memread;
        lat_wr    <= Memwrite;
        wait_cnt  <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        wait_cnt  <= wait_cnt - 4'd1;
      end
      if (commit && cur_rd && access_ok)
        rdata <= cur_wr ? 32'd0 : load_val;
    end
  end

  // Array has no reset; writes land only on the edge entering RESP
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && access_ok) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[cur_idx][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed load/store sequence with a scoreboard of
// expected responses; honours DMEM_MISALIGN_TRAP_EN for the misaligned-load step.
module tb_data_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        Memread, Memwrite;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, misalign;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .Memread(Memread), .Memwrite(Memwrite),
    .func3(func3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .misalign(misalign)
  );

  always @(posedge clk) if (done === 1'b1) done_count++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request and queue the response the core should eventually see
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input bit exp_mis);
    exp_t e;
    Memread  = rd;
    Memwrite = wr;
    func3    = f3;
    addr     = a;
    wdata    = wd;
    e.rdata  = exp_rd;
    e.mis    = exp_mis;
    sb.push_back(e);
  endtask

  task automatic runAccess(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_mis, input bit hold);
    int   cyc = 0;
    int   stl = 0;
    exp_t e;
    @(negedge clk);
    applyStimulus(rd, wr, f3, a, wd, exp_rd, exp_mis);
    #1;
    while (done !== 1'b1 && cyc < 50) begin
      if (stall === 1'b1) stl++;
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, W + 1);
    checkOutput({tag, " stall cycles"}, stl, W + 1);
    checkOutput({tag, " stall in RESP"}, stall, 1'b0);
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, " rdata"}, rdata, e.rdata);
      checkOutput({tag, " misalign"}, misalign, e.mis);
    end
    if (!hold) begin
      @(negedge clk);
      Memread  = 1'b0;
      Memwrite = 1'b0;
      #1;
      checkOutput({tag, " done drops"}, done, 1'b0);
    end
  endtask

  initial begin
    int d0;
    reset = 1'b1; Memread = 1'b0; Memwrite = 1'b0;
    func3 = 3'b000; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset stall", stall, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset misalign", misalign, 1'b0);
    reset = 1'b0;

    $display("[TB] word store/load");
    runAccess("SW 0x10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    runAccess("LW 0x10", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

    $display("[TB] byte store and sized loads");
    runAccess("SB 0x11", 0, 1, 3'b000, 32'h11, 32'h12345680, 32'hDEADBEEF, 0, 0);
    runAccess("LW 0x10b", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, 0);
    runAccess("LB 0x11", 1, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0, 0);
    runAccess("LBU 0x11", 1, 0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0, 0);
    runAccess("LH 0x12", 1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
    runAccess("LHU 0x12", 1, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, 0);

    $display("[TB] back-to-back with held request");
    d0 = done_count;
    runAccess("LW held", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, 1);
    runAccess("LBU next", 1, 0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 0, 0);
    repeat (W + 3) @(negedge clk);
    checkOutput("b2b done pulses", done_count - d0, 2);

    $display("[TB] read+write, half store, address wrap");
    runAccess("RW 0x24", 1, 1, 3'b010, 32'h24, 32'h0BADF00D, 32'h0, 0, 0);
    runAccess("SH 0x26", 0, 1, 3'b001, 32'h26, 32'hAAAA5555, 32'h0, 0, 0);
    runAccess("LW011 0x424", 1, 0, 3'b011, 32'h424, 32'h0, 32'h5555F00D, 0, 0);

    $display("[TB] reset during wait states");
    runAccess("SW 0x20", 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h5555F00D, 0, 0);
    @(negedge clk);
    Memwrite = 1'b1; Memread = 1'b0; func3 = 3'b010; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    checkOutput("abort in WAIT stall", stall, 1'b1);
    reset = 1'b1; Memwrite = 1'b0;
    @(negedge clk);
    checkOutput("abort rdata", rdata, 32'd0);
    checkOutput("abort stall", stall, 1'b0);
    checkOutput("abort done", done, 1'b0);
    checkOutput("abort misalign", misalign, 1'b0);
    reset = 1'b0;
    runAccess("LW 0x20", 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

    $display("[TB] misaligned word load");
`ifdef DMEM_MISALIGN_TRAP_EN
    runAccess("LW 0x13", 1, 0, 3'b010, 32'h13, 32'h0, 32'hCAFEF00D, 1, 0);
`else
    runAccess("LW 0x13", 1, 0, 3'b010, 32'h13, 32'h0, 32'hDEAD80EF, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
